// File: rtl/mult_div_unit_if.sv
// Operand, control and result bundle between the EX stage and the
// iterative multiply/divide unit.
interface mult_div_unit_if;
    logic [31:0] md_A;
    logic [31:0] md_B;
    logic [3:0]  MDUCtrl;
    logic        md_start;
    logic        md_rd_hi;
    logic        md_busy;
    logic [31:0] md_hi;
    logic [31:0] md_lo;
    logic [31:0] md_out;

    modport master (
        output md_A,
        output md_B,
        output MDUCtrl,
        output md_start,
        output md_rd_hi,
        input  md_busy,
        input  md_hi,
        input  md_lo,
        input  md_out
    );

    modport slave (
        input  md_A,
        input  md_B,
        input  MDUCtrl,
        input  md_start,
        input  md_rd_hi,
        output md_busy,
        output md_hi,
        output md_lo,
        output md_out
    );
endinterface

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit: fixed-latency mult/div into HI/LO,
// plus mthi/mtlo writes and the HI/LO read port for mfhi/mflo.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic            clk,
    input logic            reset_n,
    mult_div_unit_if.slave md
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    logic [3:0]  count, count_nx;
    logic [31:0] hi, hi_nx;
    logic [31:0] lo, lo_nx;
    logic [31:0] hi_s, hi_s_nx;
    logic [31:0] lo_s, lo_s_nx;
    logic        skip_s, skip_s_nx;

    logic        idle;
    logic        go;
    logic        is_mult, is_multu;
    logic        is_div, is_divu;
    logic        is_mthi, is_mtlo;

    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg, b_zero;
    logic [31:0] a_mag, b_mag;
    logic [31:0] q_mag, r_mag;
    logic [31:0] q_s, r_s, q_u, r_u;

    assign idle = (count == 4'd0);
    assign go   = md.md_start & idle;

    assign is_mult  = (md.MDUCtrl == OP_MULT);
    assign is_multu = (md.MDUCtrl == OP_MULTU);
    assign is_div   = (md.MDUCtrl == OP_DIV);
    assign is_divu  = (md.MDUCtrl == OP_DIVU);
    assign is_mthi  = (md.MDUCtrl == OP_MTHI);
    assign is_mtlo  = (md.MDUCtrl == OP_MTLO);

    // Low 64 bits of a product of sign-extended operands equal the signed product
    assign prod_s = {{32{md.md_A[31]}}, md.md_A}
                  * {{32{md.md_B[31]}}, md.md_B};
    assign prod_u = {32'd0, md.md_A} * {32'd0, md.md_B};

    assign a_neg  = md.md_A[31];
    assign b_neg  = md.md_B[31];
    assign b_zero = (md.md_B == 32'd0);
    assign a_mag  = a_neg ? (32'd0 - md.md_A) : md.md_A;
    assign b_mag  = b_neg ? (32'd0 - md.md_B) : md.md_B;

    // Magnitude division keeps truncation toward zero and defines -2^31 / -1
    assign q_mag = b_zero ? 32'd0 : (a_mag / b_mag);
    assign r_mag = b_zero ? 32'd0 : (a_mag % b_mag);
    assign q_s   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign r_s   = a_neg ? (32'd0 - r_mag) : r_mag;
    assign q_u   = b_zero ? 32'd0 : (md.md_A / md.md_B);
    assign r_u   = b_zero ? 32'd0 : (md.md_A % md.md_B);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count  <= 4'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            hi_s   <= 32'd0;
            lo_s   <= 32'd0;
            skip_s <= 1'b0;
        end else begin
            count  <= count_nx;
            hi     <= hi_nx;
            lo     <= lo_nx;
            hi_s   <= hi_s_nx;
            lo_s   <= lo_s_nx;
            skip_s <= skip_s_nx;
        end
    end

    always_comb begin
        count_nx  = count;
        hi_nx     = hi;
        lo_nx     = lo;
        hi_s_nx   = hi_s;
        lo_s_nx   = lo_s;
        skip_s_nx = skip_s;
        if (!idle) begin
            count_nx = count - 4'd1;
            if ((count == 4'd1) && !skip_s) begin
                hi_nx = hi_s;
                lo_nx = lo_s;
            end
        end else if (go) begin
            unique case (1'b1)
                is_mult: begin
                    hi_s_nx   = prod_s[63:32];
                    lo_s_nx   = prod_s[31:0];
                    skip_s_nx = 1'b0;
                    count_nx  = 4'(MULT_CYCLES);
                end
                is_multu: begin
                    hi_s_nx   = prod_u[63:32];
                    lo_s_nx   = prod_u[31:0];
                    skip_s_nx = 1'b0;
                    count_nx  = 4'(MULT_CYCLES);
                end
                is_div: begin
                    hi_s_nx   = r_s;
                    lo_s_nx   = q_s;
                    skip_s_nx = b_zero;
                    count_nx  = 4'(DIV_CYCLES);
                end
                is_divu: begin
                    hi_s_nx   = r_u;
                    lo_s_nx   = q_u;
                    skip_s_nx = b_zero;
                    count_nx  = 4'(DIV_CYCLES);
                end
                is_mthi: hi_nx = md.md_A;
                is_mtlo: lo_nx = md.md_A;
                default: ;
            endcase
        end
    end

    always_comb begin
        md.md_busy = (count != 4'd0);
        md.md_hi   = hi;
        md.md_lo   = lo;
        md.md_out  = md.md_rd_hi ? hi : lo;
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table of ops with
// hand-computed HI/LO, plus overlap and mid-operation reset sequences.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b1;

    mult_div_unit_if bus ();

    mult_div_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .md     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          cyc;
        string       name;
    } vec_t;

    vec_t        tbl[13];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Entered at a negedge; start edge is the next posedge (cycle T)
    task automatic run_op(input vec_t v);
        chk({v.name, " busy@T"}, 32'(bus.md_busy), 32'd0);
        bus.MDUCtrl = v.ctrl;
        bus.md_A = v.a;
        bus.md_B = v.b;
        bus.md_start = 1'b1;
        @(negedge clk);
        bus.md_start = 1'b0;
        bus.MDUCtrl = 4'd0;
        bus.md_A = 32'hDEADBEEF;
        bus.md_B = 32'h0BADF00D;
        for (int i = 1; i <= v.cyc; i++) begin
            chk({v.name, " busy"}, 32'(bus.md_busy), 32'd1);
            chk({v.name, " old hi"}, bus.md_hi, mhi);
            chk({v.name, " old out"}, bus.md_out, mlo);
            @(negedge clk);
        end
        chk({v.name, " busy done"}, 32'(bus.md_busy), 32'd0);
        chk({v.name, " hi"}, bus.md_hi, v.ehi);
        chk({v.name, " lo"}, bus.md_lo, v.elo);
        bus.md_rd_hi = 1'b1;
        #1;
        chk({v.name, " out hi"}, bus.md_out, v.ehi);
        bus.md_rd_hi = 1'b0;
        #1;
        chk({v.name, " out lo"}, bus.md_out, v.elo);
        mhi = v.ehi;
        mlo = v.elo;
    endtask

    initial begin
        vec_t v;
        tbl[0]  = '{4'd1, 32'hFFFFFFFD, 32'd5,
                    32'hFFFFFFFF, 32'hFFFFFFF1, 5, "mult"};
        tbl[1]  = '{4'd2, 32'hFFFFFFFF, 32'd2,
                    32'h00000001, 32'hFFFFFFFE, 5, "multu"};
        tbl[2]  = '{4'd3, 32'hFFFFFFF9, 32'd2,
                    32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div"};
        tbl[3]  = '{4'd4, 32'hFFFFFFF9, 32'd2,
                    32'h00000001, 32'h7FFFFFFC, 10, "divu"};
        tbl[4]  = '{4'd1, 32'h80000000, 32'h80000000,
                    32'h40000000, 32'h00000000, 5, "mult min"};
        tbl[5]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF,
                    32'h00000000, 32'h80000000, 10, "div ovf"};
        tbl[6]  = '{4'd3, 32'h00000007, 32'hFFFFFFFE,
                    32'h00000001, 32'hFFFFFFFD, 10, "div negb"};
        tbl[7]  = '{4'd4, 32'd100, 32'd7,
                    32'h00000002, 32'h0000000E, 10, "divu 100/7"};
        tbl[8]  = '{4'd5, 32'h12345678, 32'd0,
                    32'h12345678, 32'h0000000E, 0, "mthi"};
        tbl[9]  = '{4'd6, 32'h9ABCDEF0, 32'd0,
                    32'h12345678, 32'h9ABCDEF0, 0, "mtlo"};
        tbl[10] = '{4'd3, 32'h00000055, 32'd0,
                    32'h12345678, 32'h9ABCDEF0, 10, "div0"};
        tbl[11] = '{4'd7, 32'hFFFFFFFF, 32'd3,
                    32'h12345678, 32'h9ABCDEF0, 0, "op7"};
        tbl[12] = '{4'd4, 32'hFFFFFFFF, 32'd0,
                    32'h12345678, 32'h9ABCDEF0, 10, "divu0"};

        bus.md_A = 32'd0;
        bus.md_B = 32'd0;
        bus.MDUCtrl = 4'd0;
        bus.md_start = 1'b0;
        bus.md_rd_hi = 1'b0;

        #2 reset_n = 1'b0;
        #1;
        chk("rst busy", 32'(bus.md_busy), 32'd0);
        chk("rst hi", bus.md_hi, 32'd0);
        chk("rst lo", bus.md_lo, 32'd0);
        chk("rst out", bus.md_out, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int k = 0; k < 13; k++) run_op(tbl[k]);

        // Start attempt while busy must be ignored
        bus.MDUCtrl = 4'd1;
        bus.md_A = 32'd6;
        bus.md_B = 32'd7;
        bus.md_start = 1'b1;
        @(negedge clk);
        bus.md_start = 1'b0;
        @(negedge clk);
        bus.MDUCtrl = 4'd4;
        bus.md_A = 32'd100;
        bus.md_B = 32'd7;
        bus.md_start = 1'b1;
        @(negedge clk);
        bus.md_start = 1'b0;
        bus.MDUCtrl = 4'd0;
        chk("ovl busy T+3", 32'(bus.md_busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("ovl busy T+5", 32'(bus.md_busy), 32'd1);
        chk("ovl old lo", bus.md_lo, 32'h9ABCDEF0);
        @(negedge clk);
        chk("ovl busy T+6", 32'(bus.md_busy), 32'd0);
        chk("ovl hi", bus.md_hi, 32'd0);
        chk("ovl lo", bus.md_lo, 32'd42);
        @(negedge clk);
        chk("ovl busy T+7", 32'(bus.md_busy), 32'd0);
        chk("ovl lo T+7", bus.md_lo, 32'd42);

        // Reset in the middle of a divide abandons it
        bus.MDUCtrl = 4'd3;
        bus.md_A = 32'd100;
        bus.md_B = 32'd7;
        bus.md_start = 1'b1;
        @(negedge clk);
        bus.md_start = 1'b0;
        bus.MDUCtrl = 4'd0;
        repeat (3) @(negedge clk);
        chk("mid busy T+4", 32'(bus.md_busy), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid rst busy", 32'(bus.md_busy), 32'd0);
        chk("mid rst hi", bus.md_hi, 32'd0);
        chk("mid rst lo", bus.md_lo, 32'd0);
        chk("mid rst out", bus.md_out, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post rst busy", 32'(bus.md_busy), 32'd0);
            chk("post rst lo", bus.md_lo, 32'd0);
        end
        mhi = 32'd0;
        mlo = 32'd0;
        v = '{4'd1, 32'd3, 32'd4, 32'd0, 32'd12, 5, "mult post rst"};
        run_op(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
